// File: rtl/tx_arbiter_if.sv
// Bus between requesters, tx_arbiter and the downstream uart_tx.
// slave: arbiter side; master: requester/uart side.
interface tx_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   req_start;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     owner;
  logic              busy;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic              tx_active;
  logic              tx_done;
  logic              overrun;

  modport slave (
    input  req, req_start, req_data, tx_active, tx_done,
    output grant, owner, busy, tx_data, tx_start, overrun
  );

  modport master (
    output req, req_start, req_data, tx_active, tx_done,
    input  grant, owner, busy, tx_data, tx_start, overrun
  );
endinterface

// File: rtl/tx_arbiter.sv
// tx_arbiter: grants one of NREQ requesters a session on a shared uart_tx and
// forwards only the owner's byte starts. Define TX_ARBITER_RR_EN for round-robin
// arbitration; otherwise the lowest requesting index wins.
module tx_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input logic         clk,
  input logic         rst,
  tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StDrain} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_start_q, tx_start_d;
  logic            overrun_q, overrun_d;
  // Set with tx_start, held until uart_tx shows it has taken the byte.
  logic            pend_q, pend_d;

  logic            win_valid;
  logic [IW-1:0]   win_idx;
  logic [7:0]      data_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_data
    assign data_arr[g] = bus.req_data[8*g +: 8];
  end

`ifdef TX_ARBITER_RR_EN
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin winner: first requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NREQ;
      if (!win_valid && bus.req[idx[IW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = idx[IW-1:0];
      end
    end
  end

  // Pointer moves just past each new owner.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == StIdle && win_valid) begin
      rr_ptr_d = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority winner: lowest requesting index.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!win_valid && bus.req[i[IW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = i[IW-1:0];
      end
    end
  end
`endif

  // Session FSM, start forwarding and overrun detection.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    overrun_d  = overrun_q;
    pend_d     = pend_q && !(bus.tx_active || bus.tx_done);

    unique case (state_q)
      StIdle: begin
        // Starts arriving with req are not forwarded; the requester re-issues after grant.
        grant_d = '0;
        if (win_valid) begin
          grant_d[win_idx] = 1'b1;
          owner_d          = win_idx;
          state_d          = StGrant;
        end
      end
      StGrant: begin
        if (!bus.req[owner_q]) begin
          grant_d = '0;
          state_d = (bus.tx_active || pend_q) ? StDrain : StIdle;
        end else if (bus.req_start[owner_q]) begin
          if (bus.tx_active || pend_q) begin
            overrun_d = 1'b1;
          end else begin
            tx_start_d = 1'b1;
            tx_data_d  = data_arr[owner_q];
            pend_d     = 1'b1;
          end
        end
      end
      StDrain: begin
        grant_d = '0;
        if (!bus.tx_active && !pend_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset does not wait for uart_tx.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      owner_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      overrun_q  <= overrun_d;
      pend_q     <= pend_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = (state_q != StIdle);
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter (NREQ=4). Expectations follow TX_ARBITER_RR_EN.
module tb_tx_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  tx_arbiter_if #(.NREQ(4)) bus ();

  tx_arbiter #(.NREQ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 32'h0);
    chk({tag, "_owner"}, 32'(bus.owner), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_txstart"}, 32'(bus.tx_start), 32'h0);
    chk({tag, "_txdata"}, 32'(bus.tx_data), 32'h0);
    chk({tag, "_overrun"}, 32'(bus.overrun), 32'h0);
  endtask

  initial begin
    logic [3:0] exp_g [4];
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.req       = '0;
    bus.req_start = '0;
    bus.req_data  = '0;
    bus.tx_active = 1'b0;
    bus.tx_done   = 1'b0;

    // Reset state
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;

    // Idle with no requests
    tick();
    chk("idle_grant", 32'(bus.grant), 32'h0);
    chk("idle_busy", 32'(bus.busy), 32'h0);

    // Single requester; start arriving with req is not forwarded
    bus.req       = 4'b0100;
    bus.req_start = 4'b0100;
    bus.req_data  = 32'h0077_0000;
    tick();
    chk("single_grant", 32'(bus.grant), 32'h4);
    chk("single_owner", 32'(bus.owner), 32'h2);
    chk("single_busy", 32'(bus.busy), 32'h1);
    chk("early_start_dropped", 32'(bus.tx_start), 32'h0);
    chk("early_data_unchanged", 32'(bus.tx_data), 32'h0);

    bus.req_start = 4'b0100;
    bus.req_data  = 32'h00A5_0000;
    tick();
    chk("fwd_start", 32'(bus.tx_start), 32'h1);
    chk("fwd_data", 32'(bus.tx_data), 32'hA5);

    bus.req_start = 4'b0000;
    bus.req_data  = 32'h0;
    tick();
    chk("start_one_cycle", 32'(bus.tx_start), 32'h0);
    chk("data_held", 32'(bus.tx_data), 32'hA5);

    // uart takes the byte and completes it
    bus.tx_active = 1'b1;
    tick();
    bus.tx_active = 1'b0;
    bus.tx_done   = 1'b1;
    tick();
    bus.tx_done   = 1'b0;

    // Foreign start while the uart is free
    bus.req_start = 4'b0001;
    bus.req_data  = 32'h0000_003C;
    tick();
    chk("foreign_txstart", 32'(bus.tx_start), 32'h0);
    chk("foreign_txdata", 32'(bus.tx_data), 32'hA5);
    chk("foreign_overrun", 32'(bus.overrun), 32'h0);
    bus.req_start = 4'b0000;

    // Owner start while uart busy
    bus.tx_active = 1'b1;
    bus.req_start = 4'b0100;
    bus.req_data  = 32'h0011_0000;
    tick();
    chk("ovr_txstart", 32'(bus.tx_start), 32'h0);
    chk("ovr_flag", 32'(bus.overrun), 32'h1);
    bus.req_start = 4'b0000;
    tick();
    chk("ovr_sticky", 32'(bus.overrun), 32'h1);
    chk("ovr_data_kept", 32'(bus.tx_data), 32'hA5);

    // Owner drops req mid-byte with requester 0 waiting
    bus.req = 4'b0001;
    tick();
    chk("drain_grant", 32'(bus.grant), 32'h0);
    chk("drain_busy", 32'(bus.busy), 32'h1);
    tick();
    chk("drain_grant2", 32'(bus.grant), 32'h0);
    chk("drain_busy2", 32'(bus.busy), 32'h1);
    bus.tx_active = 1'b0;
    tick();
    chk("drain_idle_grant", 32'(bus.grant), 32'h0);
    chk("drain_idle_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("after_drain_grant", 32'(bus.grant), 32'h1);
    chk("after_drain_owner", 32'(bus.owner), 32'h0);
    chk("ovr_still_set", 32'(bus.overrun), 32'h1);
    bus.req = 4'b0000;
    tick();
    chk("end_grant", 32'(bus.grant), 32'h0);
    chk("end_busy", 32'(bus.busy), 32'h0);

    // Async reset mid-session, between edges
    bus.req = 4'b0010;
    tick();
    chk("ar_grant", 32'(bus.grant), 32'h2);
    bus.req_start = 4'b0010;
    bus.req_data  = 32'h0000_5A00;
    tick();
    chk("ar_txstart", 32'(bus.tx_start), 32'h1);
    chk("ar_txdata", 32'(bus.tx_data), 32'h5A);
    bus.req_start = 4'b0000;
    bus.tx_active = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("async");
    bus.req       = 4'b0000;
    bus.tx_active = 1'b0;
    tick();
    rst = 1'b0;
    bus.req = 4'b0001;
    tick();
    chk("post_rst_grant", 32'(bus.grant), 32'h1);
    chk("post_rst_busy", 32'(bus.busy), 32'h1);
    bus.req = 4'b0000;
    tick();

    // Contention: requesters 1 and 3, each session ended by its owner dropping req
`ifdef TX_ARBITER_RR_EN
    exp_g[0] = 4'b0010; exp_g[1] = 4'b1000; exp_g[2] = 4'b0010; exp_g[3] = 4'b1000;
`else
    exp_g[0] = 4'b0010; exp_g[1] = 4'b0010; exp_g[2] = 4'b0010; exp_g[3] = 4'b0010;
`endif
    for (int s = 0; s < 4; s++) begin
      bus.req = 4'b1010;
      tick();
      chk($sformatf("cont_grant%0d", s), 32'(bus.grant), 32'(exp_g[s]));
      bus.req = 4'b1010 & ~exp_g[s];
      tick();
      chk($sformatf("cont_gap%0d", s), 32'(bus.grant), 32'h0);
    end
    bus.req = 4'b0000;
    tick();
    chk("final_busy", 32'(bus.busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_arbiter.md
TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter IW, default $clog2(NREQ), owner index width.
REQ-003 SHALL have port clk  input  1  50 MHz system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  NREQ  per-requester session request, held high for the whole session.
REQ-006 SHALL have port req_start  input  NREQ  per-requester byte-start pulse, one cycle.
REQ-007 SHALL have port req_data  input  NREQ*8  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 SHALL have port grant  output  NREQ  one-hot session grant, registered.
REQ-009 SHALL have port owner  output  IW  index of the granted requester; valid only while busy=1.
REQ-010 SHALL have port busy  output  1  a session is granted or draining.
REQ-011 SHALL have port tx_data  output  8  byte to uart_tx, registered.
REQ-012 SHALL have port tx_start  output  1  start pulse to uart_tx, registered.
REQ-013 SHALL have port tx_active  input  1  uart_tx shifting a byte.
REQ-014 SHALL have port tx_done  input  1  uart_tx byte-complete pulse.
REQ-015 SHALL have port overrun  output  1  sticky flag: the owner's start was dropped.

Function
REQ-016 SHALL implement states IDLE, GRANT and DRAIN.
REQ-017 IDLE: when any req bit is high, SHALL select a winner and enter GRANT; grant[winner] and busy SHALL assert on the next edge.
REQ-018 IDLE with req=0 SHALL hold grant=0, busy=0 and tx_start=0.
REQ-019 GRANT: a req_start[owner] pulse while tx_active=0 and no start is pending SHALL produce tx_start=1 for exactly one cycle, one cycle later, with tx_data=req_data[owner] sampled in the same cycle.
REQ-020 A start is pending from tx_start=1 until the first cycle tx_active=1 or tx_done=1 is seen.
REQ-021 req_start[owner] while tx_active=1 or a start is pending SHALL be dropped and SHALL set overrun.
REQ-022 req_start from any non-owner requester SHALL be ignored and SHALL NOT set overrun.
REQ-023 tx_data SHALL hold its last value between starts.
REQ-024 GRANT: when req[owner] falls, SHALL drop grant on the next edge and enter DRAIN if tx_active=1 or a start is pending, otherwise enter IDLE.
REQ-025 DRAIN: SHALL keep busy=1 and grant=0, forward no starts, and enter IDLE in the first cycle in which tx_active=0 and no start is pending.
REQ-026 After each session, at least one IDLE cycle with grant=0 SHALL occur before the next grant.
REQ-027 req and req_start on the same cycle in IDLE SHALL NOT forward that start; the requester must re-issue it after it sees grant.
REQ-028 overrun SHALL clear only on rst.
REQ-029 grant SHALL never have more than one bit set.

Reset
REQ-030 rst=1 SHALL immediately force state=IDLE, grant=0, owner=0, busy=0, tx_start=0, tx_data=8'h00, overrun=0, start-pending=0 and the round-robin pointer to 0.
REQ-031 rst asserted mid-byte SHALL NOT wait for tx_active; on release, SHALL start in IDLE and arbitrate normally.

Configuration
REQ-032 Macro TX_ARBITER_RR_EN defined: winner SHALL be the first requesting index after the previous owner, wrapping modulo NREQ; after reset the search SHALL start at index 0.
REQ-033 Macro TX_ARBITER_RR_EN undefined: winner SHALL be the lowest requesting index (fixed priority), and the pointer logic SHALL be omitted.

Verification
REQ-034 Single requester: NREQ=4, req=4'b0100 -> next edge grant=4'b0100, owner=2, busy=1; req_start[2] with data 8'hA5 -> next cycle tx_start=1, tx_data=8'hA5.
REQ-035 Contention: req=4'b1010 held, sessions end by dropping req -> RR build grants 1, 3, 1, 3; fixed build grants 1 every time while bit 1 re-requests.
REQ-036 Overrun: owner pulses req_start while tx_active=1 -> no tx_start, overrun=1 and stays 1 until rst.
REQ-037 Drain: owner drops req while tx_active=1 -> grant=0 and busy=1 until tx_active falls; another waiting request is granted no earlier than one IDLE cycle later.
REQ-038 Foreign start: non-owner pulses req_start with data 8'h3C -> tx_start stays 0, tx_data unchanged, overrun=0.
REQ-039 Async reset: rst asserted mid-session, between clock edges -> all outputs reach reset values before the next edge; after release, req=4'b0001 -> grant=4'b0001 one edge later.
